// File: rtl/weight_fetch.sv
// weight_fetch: streams a contiguous run of words out of the weight SRAM (WM)
// onto a valid/ready stream in address order. A small FIFO absorbs the
// SRAM's read latency and consumer back-pressure.
//
// Optional feature: define WF_STALL_CNT_EN to build the saturating stall
// counter on stall_cycles_o. When it is undefined, stall_cycles_o is tied
// to zero and no counter logic exists.
//
// Stream handshake: w_valid_o is high whenever the FIFO holds a word, and
// w_data_o is then the FIFO head. A word moves on every rising clock edge
// where w_valid_o && w_ready_i. While w_valid_o is high and w_ready_i is low,
// w_data_o holds its value.
module weight_fetch #(
    parameter int ADDR_W     = 14,
    parameter int LEN_W      = 15,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              wm_cs_o,
    output logic              wm_oe_o,
    output logic [ADDR_W-1:0] wm_addr_o,
    input  logic [DATA_W-1:0] wm_dout_i,
    output logic              w_valid_o,
    output logic [DATA_W-1:0] w_data_o,
    input  logic              w_ready_i,
    output logic [31:0]       stall_cycles_o,
    output logic [1:0]        state_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e            state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued_q;
    logic [LEN_W-1:0]  popped_q;
    logic [ADDR_W-1:0] next_addr_q;
    logic [ADDR_W-1:0] wm_addr_q;
    logic              wm_cs_q;
    logic              pend_q;
    logic              busy_q;
    logic              done_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic room;
    logic can_issue;
    logic last_issue;
    logic last_pop;
    logic start_acc;

    // FIFO occupancy lookahead and the read-issue / completion decisions.
    // A read issued now lands two edges later, so the room test counts the
    // occupancy after this edge plus the read currently on the SRAM bus.
    always_comb begin
        push      = pend_q;
        pop       = (count_q != '0) && w_ready_i;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        room       = ({1'b0, count_d} + {{CNT_W{1'b0}}, wm_cs_q}) < DEPTH_L;
        can_issue  = (state_q == FETCH) && (issued_q < len_q) && room;
        last_issue = (issued_q + 1'b1) == len_q;
        last_pop   = pop && (popped_q == (len_q - 1'b1));
        start_acc  = (state_q == IDLE) && start_i;
    end

    // Control FSM: command capture, read issue, FIFO pointers and status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            next_addr_q <= '0;
            wm_addr_q   <= '0;
            wm_cs_q     <= 1'b0;
            pend_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            done_q  <= 1'b0;
            wm_cs_q <= 1'b0;
            pend_q  <= wm_cs_q;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                popped_q <= popped_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        len_q    <= len_i;
                        popped_q <= '0;
                        if (len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q      <= 1'b1;
                            wm_cs_q     <= 1'b1;
                            wm_addr_q   <= base_addr_i;
                            next_addr_q <= base_addr_i + 1'b1;
                            issued_q    <= LEN_W'(1);
                            state_q     <= (len_i == LEN_W'(1)) ? DRAIN : FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (can_issue) begin
                        wm_cs_q     <= 1'b1;
                        wm_addr_q   <= next_addr_q;
                        next_addr_q <= next_addr_q + 1'b1;
                        issued_q    <= issued_q + 1'b1;
                        if (last_issue) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // FIFO storage: SRAM data is written one edge after the read cycle ends.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= wm_dout_i;
        end
    end

`ifdef WF_STALL_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of busy cycles where a word waits on the consumer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (busy_q && (count_q != '0) && !w_ready_i && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = '0;
`endif

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign wm_cs_o   = wm_cs_q;
    assign wm_oe_o   = wm_cs_q;
    assign wm_addr_o = wm_addr_q;
    assign w_valid_o = (count_q != '0);
    assign w_data_o  = mem_q[rd_ptr_q];
    assign state_o   = state_q;

endmodule

// File: tb/tb_weight_fetch.sv
// Bench for weight_fetch: randomized transfers checked against a queue-based
// model of the word stream, read addresses, FIFO occupancy and completion.
module tb_weight_fetch;

  localparam int AW = 14;
  localparam int LW = 15;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [LW-1:0] len = '0;
  logic          w_ready = 1'b0;
  logic [DW-1:0] wm_dout = '0;
  logic          busy;
  logic          done;
  logic          wm_cs;
  logic          wm_oe;
  logic [AW-1:0] wm_addr;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic [31:0]   stall_cycles;
  logic [1:0]    state_dbg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  weight_fetch dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .base_addr_i    (base),
    .len_i          (len),
    .busy_o         (busy),
    .done_o         (done),
    .wm_cs_o        (wm_cs),
    .wm_oe_o        (wm_oe),
    .wm_addr_o      (wm_addr),
    .wm_dout_i      (wm_dout),
    .w_valid_o      (w_valid),
    .w_data_o       (w_data),
    .w_ready_i      (w_ready),
    .stall_cycles_o (stall_cycles),
    .state_o        (state_dbg)
  );

  // SRAM model: data valid the cycle after chip select
  logic [DW-1:0] wm_mem [0:(1<<AW)-1];
  always @(posedge clk) if (wm_cs) wm_dout <= wm_mem[wm_addr];

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int land_q[$];
  int cyc = 0;
  int e0 = 0;
  int exp_len = 0;
  int popped = 0;
  int landed = 0;
  int cs_cnt = 0;
  int done_cnt = 0;
  int done_base = 0;
  int done_due = -1;
  int occ;
  bit xfer_on = 0;
  bit fin = 0;
  bit first_seen = 0;
  bit chk_lat = 0;
  bit chk_last = 0;
  bit hold = 0;
  bit busy_exp;
  logic [DW-1:0] prev_data = '0;
  longint stall_exp = 0;
  int rmode = 0;
  int ridx = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // consumer ready driver
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: w_ready = 1'b1;
      1: begin
        w_ready = pat[ridx % 4];
        ridx++;
      end
      default: w_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (wm_cs) begin
        check("wm_oe", wm_oe, 1);
        check("read_expected", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) check("rd_addr", wm_addr, exp_addr_q.pop_front());
        land_q.push_back(cyc + 2);
        cs_cnt++;
      end else begin
        check("wm_oe", wm_oe, 0);
      end
      while (land_q.size() != 0 && land_q[0] <= cyc) begin
        void'(land_q.pop_front());
        landed++;
      end
      occ = landed - popped;
      check("fifo_occ_max", occ <= 4, 1);
      check("w_valid", w_valid, occ != 0);
      if (hold) begin
        check("hold_valid", w_valid, 1);
        check("hold_data", w_data, prev_data);
      end
      busy_exp = xfer_on && (cyc >= e0) && !fin;
      check("busy", busy, busy_exp);
      if (busy_exp && w_valid && !w_ready) stall_exp++;
      if (w_valid && xfer_on && !first_seen) begin
        first_seen = 1;
        if (chk_lat) check("first_valid_lat", cyc, e0 + 2);
      end
      if (w_valid && w_ready) begin
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("w_data", w_data, exp_q.pop_front());
        popped++;
        if (xfer_on && popped == exp_len) begin
          fin = 1;
          done_due = cyc + 1;
          if (chk_last) check("last_hs_cycle", cyc, e0 + exp_len + 1);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_cycle", cyc, done_due);
      end
      hold = w_valid && !w_ready;
      prev_data = w_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_xfer(input logic [AW-1:0] b, input int n, input bit lat, input bit last);
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_addr_q.delete();
    land_q.delete();
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      exp_addr_q.push_back(a);
      exp_q.push_back(wm_mem[a]);
    end
    e0 = cyc + 1;
    exp_len = n;
    popped = 0;
    landed = 0;
    cs_cnt = 0;
    fin = 0;
    first_seen = 0;
    xfer_on = (n != 0);
    chk_lat = lat;
    chk_last = last;
    stall_exp = 0;
    done_due = (n == 0) ? e0 : -1;
    done_base = done_cnt;
    start = 1'b1;
    base = b;
    len = LW'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    base = AW'($urandom);
    len = LW'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", done_cnt != done_base, 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt - done_base, 1);
    check("read_count", cs_cnt, exp_len);
    check("words_left", exp_q.size(), 0);
    check("busy_after_done", busy, 0);
`ifdef WF_STALL_CNT_EN
    check("stall_cycles", stall_cycles, stall_exp);
`else
    check("stall_cycles", stall_cycles, 0);
`endif
  endtask

  task automatic check_reset_values();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wm_cs", wm_cs, 0);
    check("rst_wm_oe", wm_oe, 0);
    check("rst_wm_addr", wm_addr, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_w_data", w_data, 0);
    check("rst_stall", stall_cycles, 0);
  endtask

  task automatic fill_pattern(input logic [AW-1:0] b, input int n, input logic [DW-1:0] first);
    for (int i = 0; i < n; i++) wm_mem[b + AW'(i)] = first + DW'(i);
  endtask

  task automatic fill_random(input logic [AW-1:0] b, input int n);
    for (int i = 0; i < n; i++) wm_mem[b + AW'(i)] = $urandom;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int db;
    base = '0;
    len = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // basic run, no back-pressure
    rmode = 0;
    fill_pattern(14'h0100, 8, 32'hA000);
    start_xfer(14'h0100, 8, 1, 1);
    wait_done(100);

    // same run with ready toggling 1,0,0,1
    rmode = 1;
    ridx = 0;
    start_xfer(14'h0100, 8, 1, 0);
    wait_done(200);

    // address wrap
    rmode = 0;
    fill_random(14'h3FFE, 4);
    start_xfer(14'h3FFE, 4, 1, 1);
    wait_done(100);

    // zero length: done next cycle, no reads
    start_xfer(14'h0200, 0, 0, 0);
    wait_done(20);

    // start during a transfer is ignored
    rmode = 1;
    ridx = 0;
    fill_random(14'h0200, 8);
    fill_random(14'h1234, 5);
    start_xfer(14'h0200, 8, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    base = 14'h1234;
    len = LW'(5);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(200);

    // reset in the middle of a transfer
    rmode = 0;
    fill_random(14'h0500, 8);
    start_xfer(14'h0500, 8, 1, 0);
    n = 0;
    while (popped < 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("three_words_seen", popped >= 3, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    xfer_on = 0;
    fin = 0;
    exp_q.delete();
    exp_addr_q.delete();
    land_q.delete();
    landed = 0;
    popped = 0;
    hold = 0;
    done_due = -1;
    db = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_done_after_abort", done_cnt, db);
    fill_random(14'h0040, 2);
    start_xfer(14'h0040, 2, 1, 1);
    wait_done(50);

    // randomized transfers with random back-pressure
    rmode = 2;
    for (int t = 0; t < 8; t++) begin
      logic [AW-1:0] b;
      int l;
      b = AW'($urandom);
      l = $urandom_range(1, 24);
      fill_random(b, l);
      start_xfer(b, l, 1, 0);
      wait_done(20 * l + 50);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/weight_fetch.md
# weight_fetch

Read-stream engine between the weight SRAM (WM) and the accelerator datapath. On a start command it reads a contiguous run of 32-bit words from WM and presents them in address order on a valid/ready stream. A small internal FIFO absorbs the SRAM's one-cycle read latency and downstream back-pressure. Sustained throughput is one word per cycle.

## Interface
- ADDR_W, 14, WM word-address width; addresses wrap modulo 2^ADDR_W
- LEN_W, 15, transfer-length width in words
- DATA_W, 32, word width
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle command pulse; sampled only in IDLE
- base_addr  in  ADDR_W  first word address; sampled with start
- len  in  LEN_W  word count; sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle completion pulse
- wm_cs  out  1  WM chip select for a read this cycle
- wm_oe  out  1  WM output enable; equals wm_cs
- wm_addr  out  ADDR_W  WM read address
- wm_dout  in  DATA_W  WM read data; valid the cycle after wm_cs
- w_valid  out  1  stream word available
- w_data  out  DATA_W  stream word, FIFO head
- w_ready  in  1  consumer accepts; transfer on w_valid && w_ready
- stall_cycles  out  32  back-pressure counter (see Configuration)

## Operation
- FSM states IDLE, FETCH, DRAIN.
- IDLE: when start=1, latch base_addr, len and go to FETCH. If len=0, go directly to IDLE and pulse done the next cycle with no WM access. start in any other state is ignored.
- FETCH: issue one read per cycle while `issued < len` and `fifo_count + inflight < FIFO_DEPTH`. inflight is 0 or 1. Address increments by 1 per issue and wraps from 2^ADDR_W−1 to 0. After the last issue, go to DRAIN.
- Each read's data is written into the FIFO on the edge after its issue cycle. A FIFO write and a read (pop) may occur in the same cycle. In that case fifo_count is unchanged.
- DRAIN: stay until the `len`-th word has been popped by a handshake. Then return to IDLE and pulse done.
- w_valid = (fifo_count ≠ 0). w_data is stable while w_valid && !w_ready.
- The FIFO never overflows, by construction of the issue condition. A pop when the FIFO is empty is impossible because w_valid=0.
- Words are emitted in strictly increasing (wrapping) address order. No word is dropped or duplicated.

## Timing
- Reset values: busy=0, done=0, wm_cs=0, wm_oe=0, wm_addr=0, w_valid=0, w_data=0, stall_cycles=0. FIFO is emptied and the FSM goes to IDLE.
- Reset asserted mid-transfer aborts immediately. There is no done pulse and the FIFO contents are discarded.
- Start sampled at edge E0:
  - busy=1 and the first read (wm_addr=base_addr) are driven after E0.
  - Data is captured at E2.
  - w_valid=1 after E2. First-word latency is 2 cycles.
- With w_ready held high, one word transfers per cycle after the first.
- For len=N with no back-pressure, the last handshake occurs N+1 cycles after E0.
- done goes high for one cycle in the cycle after the last handshake edge. busy falls in the same cycle.
- A new start is accepted in the cycle done is high, because the FSM is already in IDLE.

## Configuration
- WF_STALL_CNT_EN defined:
  - stall_cycles counts cycles where busy && w_valid && !w_ready.
  - The count saturates at 0xFFFFFFFF.
  - It clears on an accepted start.
- Undefined: stall_cycles is tied to 0 and no counter logic is built. Stream behaviour is identical either way.

## Test plan
- base=0x0100, len=8, w_ready=1, WM[0x100+i]=0xA000+i → w_data 0xA000..0xA007 on consecutive cycles; first w_valid 2 cycles after start; single done pulse; wm_cs asserted exactly 8 cycles.
- Same transfer with w_ready toggling 1,0,0,1 repeating → same 8 words in order with no duplicates; FIFO occupancy never exceeds 4; w_data held during stalls; with WF_STALL_CNT_EN, stall_cycles equals the number of counted stall cycles.
- base=0x3FFE, len=4 → reads addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001, in that order.
- len=0 → done pulse the cycle after start, wm_cs never asserted, w_valid stays 0.
- start pulsed again mid-transfer with different base → ignored; original stream completes unchanged.
- rst asserted low after 3 of 8 words → all outputs return to reset values asynchronously, no done pulse; a new start with len=2 after release completes correctly.
